// File: rtl/dec_scan_n_if.sv
// Bus bundle for dec_scan_n: control inputs (en, mode, a, start) and
// decoded outputs (s, idx, busy, done).
interface dec_scan_n_if #(
   parameter int N = 3
) ();
   logic                  en;
   logic                  mode;
   logic [N-1:0]          a;
   logic                  start;
   logic [(1 << N)-1:0]   s;
   logic [N-1:0]          idx;
   logic                  busy;
   logic                  done;

   modport master (
      output en, mode, a, start,
      input  s, idx, busy, done
   );

   modport slave (
      input  en, mode, a, start,
      output s, idx, busy, done
   );
endinterface

// File: rtl/dec_scan_n.sv
// Registered N-to-2^N one-hot decoder with a self-timed scan mode.
// Define DEC_SCAN_WRAP_EN to make scans repeat continuously instead of stopping after one sweep.
module dec_scan_n #(
   parameter int N     = 3,
   parameter int DWELL = 4
) (
   input  logic          clk,
   input  logic          rst,
   dec_scan_n_if.slave   bus
);
   localparam int              W        = 1 << N;
   localparam int              CW       = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [CW-1:0]   CNT_LAST = CW'(DWELL - 1);
   localparam logic [N-1:0]    IDX_LAST = {N{1'b1}};

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_DIRECT = 2'd1;
   localparam logic [1:0] ST_SCAN   = 2'd2;

   logic [1:0]    state;
   logic [CW-1:0] cnt;
   logic [W-1:0]  s;
   logic [N-1:0]  idx;
   logic          busy;
   logic          done;

   function automatic logic [W-1:0] onehot(input logic [N-1:0] i);
      return W'(1) << i;
   endfunction

   assign bus.s    = s;
   assign bus.idx  = idx;
   assign bus.busy = busy;
   assign bus.done = done;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
         s     <= '0;
         idx   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         if (!bus.en) begin
            // idx deliberately holds so the last position stays observable
            state <= ST_IDLE;
            s     <= '0;
            busy  <= 1'b0;
            cnt   <= '0;
         end else begin
            case (state)
               ST_SCAN: begin
                  if (!bus.mode) begin
                     state <= ST_DIRECT;
                     s     <= onehot(bus.a);
                     idx   <= bus.a;
                     busy  <= 1'b0;
                     cnt   <= '0;
                  end else if (cnt == CNT_LAST) begin
                     cnt <= '0;
                     if (idx == IDX_LAST) begin
                        done <= 1'b1;
`ifdef DEC_SCAN_WRAP_EN
                        idx  <= '0;
                        s    <= onehot('0);
`else
                        state <= ST_IDLE;
                        s     <= '0;
                        busy  <= 1'b0;
`endif
                     end else begin
                        idx <= idx + 1'b1;
                        s   <= onehot(idx + 1'b1);
                     end
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               ST_IDLE, ST_DIRECT: begin
                  if (!bus.mode) begin
                     state <= ST_DIRECT;
                     s     <= onehot(bus.a);
                     idx   <= bus.a;
                  end else if (bus.start) begin
                     state <= ST_SCAN;
                     s     <= onehot('0);
                     idx   <= '0;
                     busy  <= 1'b1;
                     cnt   <= '0;
                  end else begin
                     state <= ST_IDLE;
                     s     <= '0;
                  end
               end
               default: begin
                  state <= ST_IDLE;
                  s     <= '0;
                  busy  <= 1'b0;
                  cnt   <= '0;
               end
            endcase
         end
      end
   end
endmodule
